// File: rtl/matrix_dot_sequencer_pkg.sv
// Shared constants, FSM state encoding and address helper for the matrix dot sequencer.
// Ports: none (package).
// N x N unsigned operands of DW bits, accumulated to ACCW bits, row-major addressing on AW bits.
package matrix_pkg;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int AW   = 6;
   localparam int ACCW = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      EMIT  = 2'd3
   } state_t;

   // Row-major element address.
   function automatic logic [AW-1:0] idx(input logic [AW-1:0] row, input logic [AW-1:0] col);
      return AW'(row * N + col);
   endfunction

endpackage

// File: rtl/matrix_dot_sequencer_if.sv
// Bus between the dot sequencer and its operand RAMs / result writeback.
// Ports: start, A/B read address and data, result_D/res_addr/res_valid strobe, busy, done.
// master = the sequencer; slave = memories, controller and writeback around it.
interface matrix_dot_sequencer_if;
   import matrix_pkg::*;

   logic            start;
   logic [AW-1:0]   a_addr;
   logic [AW-1:0]   b_addr;
   logic [DW-1:0]   a_data;
   logic [DW-1:0]   b_data;
   logic [ACCW-1:0] result_D;
   logic [AW-1:0]   res_addr;
   logic            res_valid;
   logic            busy;
   logic            done;

   modport master (
      input  start, a_data, b_data,
      output a_addr, b_addr, result_D, res_addr, res_valid, busy, done
   );

   modport slave (
      output start, a_data, b_data,
      input  a_addr, b_addr, result_D, res_addr, res_valid, busy, done
   );

endinterface

// File: rtl/matrix_dot_sequencer_mac_unit.sv
// Registered unsigned multiply-accumulate: acc <= a*b (load) or acc + a*b, when en is high.
// Ports: clk, reset (async active-low), en, load, a, b -> acc.
// Product is full 2*DW bits, zero-extended; the sum wraps modulo 2**ACCW.
module mac_unit
   import matrix_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            load,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [ACCW-1:0] acc
);

   logic [2*DW-1:0] prod;
   logic [ACCW-1:0] prod_ext;

   assign prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
   assign prod_ext = {{(ACCW-2*DW){1'b0}}, prod};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else if (en) begin
         acc <= load ? prod_ext : acc + prod_ext;
      end
   end

endmodule

// File: rtl/matrix_dot_sequencer.sv
// Sequences C = A x B one dot product at a time: issues A/B reads, accumulates, emits C[i][j].
// Ports: clk, reset (async active-low), bus (master modport of matrix_dot_sequencer_if).
// Per element: N ISSUE cycles, 1 DRAIN, 1 EMIT (res_valid strobe); done pulses in the IDLE cycle after the last EMIT.
module matrix_dot_sequencer
   import matrix_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   matrix_dot_sequencer_if.master  bus
);

   state_t        state_q, state_d;
   logic [AW-1:0] i_q, j_q, k_q;
   logic [AW-1:0] i_d, j_d, k_d;

   logic last_i, last_j, last_k;
   logic issue, emit;

   logic [AW-1:0]   a_cur, b_cur;
   logic [AW-1:0]   a_hold, b_hold;
   logic [ACCW-1:0] res_hold;
   logic [AW-1:0]   res_addr_q;
   logic            res_valid_q;
   logic            done_q;

   // Read data lags the issued address by one cycle, so the MAC controls are the
   // ISSUE-cycle qualifiers delayed by one register stage.
   logic            rd_vld_q;
   logic            rd_first_q;
   logic [ACCW-1:0] acc;

   assign last_i = (i_q == AW'(N-1));
   assign last_j = (j_q == AW'(N-1));
   assign last_k = (k_q == AW'(N-1));
   assign issue  = (state_q == ISSUE);
   assign emit   = (state_q == EMIT);
   assign a_cur  = idx(i_q, k_q);
   assign b_cur  = idx(k_q, j_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ISSUE;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
            end
         end
         ISSUE: begin
            if (last_k) begin
               state_d = DRAIN;
               k_d     = '0;
            end else begin
               k_d     = k_q + AW'(1);
            end
         end
         DRAIN: begin
            state_d = EMIT;
         end
         EMIT: begin
            k_d = '0;
            if (last_j) begin
               j_d = '0;
               if (last_i) begin
                  i_d     = '0;
                  state_d = IDLE;
               end else begin
                  i_d     = i_q + AW'(1);
                  state_d = ISSUE;
               end
            end else begin
               j_d     = j_q + AW'(1);
               state_d = ISSUE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_hold      <= '0;
         b_hold      <= '0;
         res_hold    <= '0;
         res_addr_q  <= '0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_first_q  <= 1'b0;
      end else begin
         if (issue) begin
            a_hold <= a_cur;
            b_hold <= b_cur;
         end
         if (emit) begin
            res_hold <= acc;
         end
         // Element coordinates are stable from ISSUE through EMIT, so the
         // write address can be registered on the DRAIN -> EMIT transition.
         if (state_q == DRAIN) begin
            res_addr_q <= idx(i_q, j_q);
         end
         res_valid_q <= (state_q == DRAIN);
         done_q      <= emit && last_i && last_j;
         rd_vld_q    <= issue;
         rd_first_q  <= issue && (k_q == '0);
      end
   end

   mac_unit u_mac (
      .clk   (clk),
      .reset (reset),
      .en    (rd_vld_q),
      .load  (rd_first_q),
      .a     (bus.a_data),
      .b     (bus.b_data),
      .acc   (acc)
   );

   // Addresses are live during ISSUE and hold their last issued value otherwise.
   assign bus.a_addr    = issue ? a_cur : a_hold;
   assign bus.b_addr    = issue ? b_cur : b_hold;
   // The accumulator is final during EMIT; afterwards the captured copy is held.
   assign bus.result_D  = emit ? acc : res_hold;
   assign bus.res_addr  = res_addr_q;
   assign bus.res_valid = res_valid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;

endmodule
